// File: rtl/axi_rd_arb2.sv
// Two-master AXI read arbiter sharing one ROM slave port; registered AR slot, in-order R steering.
// Optional macro AXI_RD_ARB_QOS_EN: higher arqos wins, round-robin breaks ties.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module axi_rd_arb2 #(
    parameter int OST_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m0_arvalid,
    output logic                          m0_arready,
    input  logic [`AXI_ID_WIDTH-1:0]      m0_arid,
    input  logic [`AXI_ADDR_WIDTH-1:0]    m0_araddr,
    input  logic [`AXI_LEN_WIDTH-1:0]     m0_arlen,
    input  logic [`AXI_SIZE_WIDTH-1:0]    m0_arsize,
    input  logic [`AXI_BURST_WIDTH-1:0]   m0_arburst,
    input  logic [`AXI_LOCK_WIDTH-1:0]    m0_arlock,
    input  logic [`AXI_CACHE_WIDTH-1:0]   m0_arcache,
    input  logic [`AXI_PROT_WIDTH-1:0]    m0_arprot,
    input  logic [`AXI_QOS_WIDTH-1:0]     m0_arqos,
    input  logic [`AXI_REGION_WIDTH-1:0]  m0_arregion,
    output logic                          m0_rvalid,
    input  logic                          m0_rready,
    output logic [`AXI_ID_WIDTH-1:0]      m0_rid,
    output logic [`AXI_DATA_WIDTH-1:0]    m0_rdata,
    output logic [`AXI_RESP_WIDTH-1:0]    m0_rresp,
    output logic                          m0_rlast,
    input  logic                          m1_arvalid,
    output logic                          m1_arready,
    input  logic [`AXI_ID_WIDTH-1:0]      m1_arid,
    input  logic [`AXI_ADDR_WIDTH-1:0]    m1_araddr,
    input  logic [`AXI_LEN_WIDTH-1:0]     m1_arlen,
    input  logic [`AXI_SIZE_WIDTH-1:0]    m1_arsize,
    input  logic [`AXI_BURST_WIDTH-1:0]   m1_arburst,
    input  logic [`AXI_LOCK_WIDTH-1:0]    m1_arlock,
    input  logic [`AXI_CACHE_WIDTH-1:0]   m1_arcache,
    input  logic [`AXI_PROT_WIDTH-1:0]    m1_arprot,
    input  logic [`AXI_QOS_WIDTH-1:0]     m1_arqos,
    input  logic [`AXI_REGION_WIDTH-1:0]  m1_arregion,
    output logic                          m1_rvalid,
    input  logic                          m1_rready,
    output logic [`AXI_ID_WIDTH-1:0]      m1_rid,
    output logic [`AXI_DATA_WIDTH-1:0]    m1_rdata,
    output logic [`AXI_RESP_WIDTH-1:0]    m1_rresp,
    output logic                          m1_rlast,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    output logic [`AXI_ID_WIDTH-1:0]      s_arid,
    output logic [`AXI_ADDR_WIDTH-1:0]    s_araddr,
    output logic [`AXI_LEN_WIDTH-1:0]     s_arlen,
    output logic [`AXI_SIZE_WIDTH-1:0]    s_arsize,
    output logic [`AXI_BURST_WIDTH-1:0]   s_arburst,
    output logic [`AXI_LOCK_WIDTH-1:0]    s_arlock,
    output logic [`AXI_CACHE_WIDTH-1:0]   s_arcache,
    output logic [`AXI_PROT_WIDTH-1:0]    s_arprot,
    output logic [`AXI_QOS_WIDTH-1:0]     s_arqos,
    output logic [`AXI_REGION_WIDTH-1:0]  s_arregion,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    input  logic [`AXI_ID_WIDTH-1:0]      s_rid,
    input  logic [`AXI_DATA_WIDTH-1:0]    s_rdata,
    input  logic [`AXI_RESP_WIDTH-1:0]    s_rresp,
    input  logic                          s_rlast,
    output logic                          arb_err
);
    localparam int PW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;
    localparam int CW = $clog2(OST_DEPTH + 1);

    typedef struct packed {
        logic [`AXI_ID_WIDTH-1:0]     id;
        logic [`AXI_ADDR_WIDTH-1:0]   addr;
        logic [`AXI_LEN_WIDTH-1:0]    len;
        logic [`AXI_SIZE_WIDTH-1:0]   size;
        logic [`AXI_BURST_WIDTH-1:0]  burst;
        logic [`AXI_LOCK_WIDTH-1:0]   lock;
        logic [`AXI_CACHE_WIDTH-1:0]  cache;
        logic [`AXI_PROT_WIDTH-1:0]   prot;
        logic [`AXI_QOS_WIDTH-1:0]    qos;
        logic [`AXI_REGION_WIDTH-1:0] region;
    } ar_t;

    ar_t                  m0_ar, m1_ar, slot;
    logic [OST_DEPTH-1:0] owner;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 rr_last, win, grant, pop, empty, head;

    assign m0_ar = {m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst,
                    m0_arlock, m0_arcache, m0_arprot, m0_arqos, m0_arregion};
    assign m1_ar = {m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst,
                    m1_arlock, m1_arcache, m1_arprot, m1_arqos, m1_arregion};

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(OST_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        win = m1_arvalid;
        if (m0_arvalid && m1_arvalid) begin
`ifdef AXI_RD_ARB_QOS_EN
            if (m0_arqos != m1_arqos) win = (m1_arqos > m0_arqos);
            else                      win = ~rr_last;
`else
            win = ~rr_last;
`endif
        end
    end

    // A completing read frees its FIFO entry in time for a same-cycle grant.
    assign empty      = (count == '0);
    assign head       = owner[rd_ptr];
    assign s_rready   = ~empty & (head ? m1_rready : m0_rready);
    assign pop        = s_rvalid & s_rready & s_rlast;
    assign grant      = ~rst & (~s_arvalid | s_arready) & ((count != CW'(OST_DEPTH)) | pop)
                        & (m0_arvalid | m1_arvalid);
    assign m0_arready = grant & ~win;
    assign m1_arready = grant & win;
    assign m0_rvalid  = s_rvalid & ~empty & ~head;
    assign m1_rvalid  = s_rvalid & ~empty & head;

    assign {m0_rid, m0_rdata, m0_rresp, m0_rlast} = {s_rid, s_rdata, s_rresp, s_rlast};
    assign {m1_rid, m1_rdata, m1_rresp, m1_rlast} = {s_rid, s_rdata, s_rresp, s_rlast};
    assign {s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
            s_arlock, s_arcache, s_arprot, s_arqos, s_arregion} = slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_arvalid <= 1'b0;
            slot      <= '0;
            owner     <= '0;
            rr_last   <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            arb_err   <= 1'b0;
        end else begin
            if (grant) begin
                s_arvalid     <= 1'b1;
                slot          <= win ? m1_ar : m0_ar;
                owner[wr_ptr] <= win;
                wr_ptr        <= nxt(wr_ptr);
                rr_last       <= win;
            end else if (s_arready) begin
                s_arvalid <= 1'b0;
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (grant && !pop)      count <= count + 1'b1;
            else if (!grant && pop) count <= count - 1'b1;
            if (s_rvalid && empty) arb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_rd_arb2.sv
// Randomized scoreboard bench for axi_rd_arb2: transaction-level model of grants, AR order and R routing.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module tb_axi_rd_arb2;
    localparam int OST = 8;

    typedef struct packed {
        logic [`AXI_ID_WIDTH-1:0]     id;
        logic [`AXI_ADDR_WIDTH-1:0]   addr;
        logic [`AXI_LEN_WIDTH-1:0]    len;
        logic [`AXI_SIZE_WIDTH-1:0]   size;
        logic [`AXI_BURST_WIDTH-1:0]  burst;
        logic [`AXI_LOCK_WIDTH-1:0]   lock;
        logic [`AXI_CACHE_WIDTH-1:0]  cache;
        logic [`AXI_PROT_WIDTH-1:0]   prot;
        logic [`AXI_QOS_WIDTH-1:0]    qos;
        logic [`AXI_REGION_WIDTH-1:0] region;
    } ar_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ar_t        m_ar [2];
    logic [1:0] m_arvalid, m_rready;
    logic m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic [`AXI_ID_WIDTH-1:0]   m0_rid, m1_rid;
    logic [`AXI_DATA_WIDTH-1:0] m0_rdata, m1_rdata;
    logic [`AXI_RESP_WIDTH-1:0] m0_rresp, m1_rresp;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, arb_err;
    logic [`AXI_ID_WIDTH-1:0]     s_arid, s_rid;
    logic [`AXI_ADDR_WIDTH-1:0]   s_araddr;
    logic [`AXI_LEN_WIDTH-1:0]    s_arlen;
    logic [`AXI_SIZE_WIDTH-1:0]   s_arsize;
    logic [`AXI_BURST_WIDTH-1:0]  s_arburst;
    logic [`AXI_LOCK_WIDTH-1:0]   s_arlock;
    logic [`AXI_CACHE_WIDTH-1:0]  s_arcache;
    logic [`AXI_PROT_WIDTH-1:0]   s_arprot;
    logic [`AXI_QOS_WIDTH-1:0]    s_arqos;
    logic [`AXI_REGION_WIDTH-1:0] s_arregion;
    logic [`AXI_DATA_WIDTH-1:0]   s_rdata;
    logic [`AXI_RESP_WIDTH-1:0]   s_rresp;
    ar_t s_ar_pl;
    assign s_ar_pl = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
                      s_arlock, s_arcache, s_arprot, s_arqos, s_arregion};

    axi_rd_arb2 #(.OST_DEPTH(OST)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m_arvalid[0]), .m0_arready(m0_arready),
        .m0_arid(m_ar[0].id), .m0_araddr(m_ar[0].addr), .m0_arlen(m_ar[0].len),
        .m0_arsize(m_ar[0].size), .m0_arburst(m_ar[0].burst), .m0_arlock(m_ar[0].lock),
        .m0_arcache(m_ar[0].cache), .m0_arprot(m_ar[0].prot), .m0_arqos(m_ar[0].qos),
        .m0_arregion(m_ar[0].region),
        .m0_rvalid(m0_rvalid), .m0_rready(m_rready[0]), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_arvalid(m_arvalid[1]), .m1_arready(m1_arready),
        .m1_arid(m_ar[1].id), .m1_araddr(m_ar[1].addr), .m1_arlen(m_ar[1].len),
        .m1_arsize(m_ar[1].size), .m1_arburst(m_ar[1].burst), .m1_arlock(m_ar[1].lock),
        .m1_arcache(m_ar[1].cache), .m1_arprot(m_ar[1].prot), .m1_arqos(m_ar[1].qos),
        .m1_arregion(m_ar[1].region),
        .m1_rvalid(m1_rvalid), .m1_rready(m_rready[1]), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock),
        .s_arcache(s_arcache), .s_arprot(s_arprot), .s_arqos(s_arqos), .s_arregion(s_arregion),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .arb_err(arb_err)
    );

    int n_chk = 0, n_fail = 0;
    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model state: pending AR slot, grant order, outstanding owners, error flag.
    ar_t  ar_q  [$];
    bit   own_q [$];
    ar_t  slv_q [$];
    bit   slot_full, rr_last, err_m;
    bit   [1:0] ar_hs;
    bit   r_hs, r_last_hs;
    int   beats_m [2];

    bit   [1:0] m_en;
    bit   slv_r_en;
    int   m_rate, rr_rate, sar_rate, rv_rate, max_len, beat;

    always @(negedge clk) begin
        bit e_srr, e_pop, can, any, w;
        ar_t exp_ar;
        ar_hs = '0; r_hs = 1'b0; r_last_hs = 1'b0;
        if (rst) begin
            ar_q.delete(); own_q.delete(); slv_q.delete();
            slot_full = 1'b0; rr_last = 1'b1; err_m = 1'b0;
        end else begin
            e_srr = (own_q.size() > 0) && m_rready[own_q[0]];
            chk("s_rready", s_rready, e_srr);
            chk("m0_rvalid", m0_rvalid, s_rvalid && own_q.size() > 0 && own_q[0] == 1'b0);
            chk("m1_rvalid", m1_rvalid, s_rvalid && own_q.size() > 0 && own_q[0] == 1'b1);
            if (s_rvalid) begin
                chk("r_bcast_m0", {m0_rid, m0_rdata, m0_rresp, m0_rlast}, {s_rid, s_rdata, s_rresp, s_rlast});
                chk("r_bcast_m1", {m1_rid, m1_rdata, m1_rresp, m1_rlast}, {s_rid, s_rdata, s_rresp, s_rlast});
            end
            chk("arb_err", arb_err, err_m);
            if (s_rvalid && own_q.size() == 0) err_m = 1'b1;
            if (s_rvalid && e_srr) beats_m[own_q[0]]++;
            e_pop     = s_rvalid && e_srr && s_rlast;
            r_hs      = s_rvalid && s_rready;
            r_last_hs = r_hs && s_rlast;

            chk("s_arvalid", s_arvalid, slot_full);
            if (s_arvalid && s_arready) begin
                if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
                else begin
                    exp_ar = ar_q.pop_front();
                    chk("s_ar_payload", s_ar_pl, exp_ar);
                end
                slv_q.push_back(s_ar_pl);
            end

            can = (!slot_full || s_arready) && (own_q.size() < OST || e_pop);
            w   = m_arvalid[1];
            if (m_arvalid[0] && m_arvalid[1]) begin
`ifdef AXI_RD_ARB_QOS_EN
                if (m_ar[0].qos != m_ar[1].qos) w = (m_ar[1].qos > m_ar[0].qos);
                else                            w = !rr_last;
`else
                w = !rr_last;
`endif
            end
            any = can && (m_arvalid[0] || m_arvalid[1]);
            chk("m0_arready", m0_arready, any && !w);
            chk("m1_arready", m1_arready, any && w);
            ar_hs[0] = m_arvalid[0] && m0_arready;
            ar_hs[1] = m_arvalid[1] && m1_arready;

            if (e_pop) void'(own_q.pop_front());
            if (any) begin
                ar_q.push_back(m_ar[w]);
                own_q.push_back(w);
                rr_last   = w;
                slot_full = 1'b1;
            end else if (s_arready) begin
                slot_full = 1'b0;
            end
        end
    end

    function automatic ar_t rand_ar();
        logic [95:0] r;
        ar_t a;
        r = {$urandom, $urandom, $urandom};
        a = r[$bits(ar_t)-1:0];
        a.len   = `AXI_LEN_WIDTH'($urandom_range(max_len));
        a.size  = `AXI_SIZE_WIDTH'(2);
        a.burst = `AXI_BURST_WIDTH'(1);
        a.qos   = `AXI_QOS_WIDTH'($urandom_range(3));
        return a;
    endfunction

    task automatic step();
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            if (ar_hs[m] || !m_arvalid[m]) begin
                if (m_en[m] && $urandom_range(99) < m_rate) begin
                    m_arvalid[m] = 1'b1;
                    m_ar[m]      = rand_ar();
                end else begin
                    m_arvalid[m] = 1'b0;
                end
            end
            m_rready[m] = ($urandom_range(99) < rr_rate);
        end
        s_arready = ($urandom_range(99) < sar_rate);
        if (r_hs) begin
            s_rvalid = 1'b0;
            if (s_rlast) begin
                beat = 0;
                if (slv_q.size() > 0) void'(slv_q.pop_front());
            end else begin
                beat++;
            end
        end
        if (!s_rvalid && slv_r_en && slv_q.size() > 0 && $urandom_range(99) < rv_rate) begin
            s_rvalid = 1'b1;
            s_rid    = slv_q[0].id;
            s_rdata  = $urandom;
            s_rresp  = `AXI_RESP_WIDTH'($urandom_range(3));
            s_rlast  = (beat == int'(slv_q[0].len));
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        m_en = 2'b00; slv_r_en = 1'b1; rr_rate = 100; rv_rate = 100; sar_rate = 100;
        for (int i = 0; i < 500 && !done; i++) begin
            step();
            done = (own_q.size() == 0) && !slot_full && !s_rvalid && (m_arvalid == 2'b00);
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset(int cyc);
        @(posedge clk); #1;
        rst = 1'b1; m_arvalid = '0; s_rvalid = 1'b0; s_rlast = 1'b0; beat = 0;
        repeat (cyc) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Eight single-beat reads fill the arbiter; the ninth goes through on the first rlast.
    task automatic fill_test(string tag);
        int acc = 0;
        bit seen = 1'b0;
        drain();
        m_en = 2'b10; m_rate = 100; sar_rate = 100; slv_r_en = 1'b0; max_len = 0;
        repeat (30) begin
            step();
            acc += int'(ar_hs[1]);
        end
        chk({tag, "_accepted"}, acc, OST);
        slv_r_en = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (r_last_hs) begin
                seen = 1'b1;
                chk({tag, "_regrant_same_cycle"}, ar_hs[1], 1);
            end
        end
        if (!seen) chk({tag, "_rlast_timeout"}, 0, 1);
    endtask

    initial begin
        ar_t a;
        rst = 1'b1; m_arvalid = '0; m_rready = '0; s_arready = 1'b0; s_rvalid = 1'b0;
        s_rlast = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0;
        m_ar[0] = '0; m_ar[1] = '0; beat = 0; m_en = '0; slv_r_en = 1'b0; max_len = 0;
        m_rate = 100; rr_rate = 100; sar_rate = 100; rv_rate = 100;
        m_arvalid[0] = 1'b1; s_rvalid = 1'b1; m_rready = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_m0_arready", m0_arready, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_arb_err", arb_err, 0);
        chk("rst_s_araddr", s_araddr, 0);
        @(posedge clk); #1;
        m_arvalid = '0; s_rvalid = 1'b0; rst = 1'b0;

        // single m0 read at 0x40
        a = rand_ar(); a.addr = 'h40; a.len = '0;
        m_ar[0] = a; m_arvalid[0] = 1'b1; s_arready = 1'b1; slv_r_en = 1'b1;
        beats_m[0] = 0; beats_m[1] = 0;
        repeat (12) step();
        chk("t1_m0_beats", beats_m[0], 1);
        chk("t1_m1_beats", beats_m[1], 0);

        m_en = 2'b11; max_len = 3;
        for (int seg = 0; seg < 5; seg++) begin
            if (seg == 0) begin
                m_rate = 100; rr_rate = 100; sar_rate = 100; rv_rate = 100; slv_r_en = 1'b1;
            end else begin
                m_rate = $urandom_range(100, 30); rr_rate = $urandom_range(100, 30);
                sar_rate = $urandom_range(100, 30); rv_rate = $urandom_range(100, 30);
                slv_r_en = 1'b1;
            end
            m_en = 2'b11;
            repeat (800) step();
        end

        fill_test("fill");

        // stray R beat with nothing outstanding
        drain();
        slv_r_en = 1'b0;
        s_rvalid = 1'b1; s_rlast = 1'b1;
        repeat (3) step();
        chk("err_set", arb_err, 1);
        s_rvalid = 1'b0;
        repeat (3) step();
        chk("err_sticky", arb_err, 1);

        // reset in the middle of traffic
        m_en = 2'b11; m_rate = 100; max_len = 3; slv_r_en = 1'b1; rr_rate = 50; sar_rate = 60;
        repeat (15) step();
        do_reset(2);
        @(negedge clk);
        chk("midrst_s_arvalid", s_arvalid, 0);
        chk("midrst_arb_err", arb_err, 0);
        fill_test("post_rst");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
